// File: rtl/alu_shifter.sv
// ARM-style ALU with a combinational barrel shifter that produces operand B.
// Separate latches can hold a register-specified shift amount and a shifted operand B.
module alu_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] op_a,
    input  logic [31:0] r_in,
    input  logic [3:0]  alu_op,
    input  logic [3:0]  flags_in,
    input  logic [1:0]  shift_type,
    input  logic [4:0]  shift_amount,
    input  logic        shift_latch_amt,
    input  logic        shift_use_latch,
    input  logic        shift_use_rrx,
    input  logic        carry_in,
    input  logic        latch_op_b,
    input  logic        use_op_b_latch,
    input  logic        disable_op_b,
    output logic [31:0] result,
    output logic [3:0]  flags_out
);

    localparam int DATA_W = 32;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    // Returns {carry, value}. In immediate mode amt never exceeds 31, so only the
    // #0 encodings of LSR/ASR need special treatment there.
    function automatic logic [DATA_W:0] barrel_shift(
        input logic [DATA_W-1:0] r,
        input logic [1:0]        typ,
        input logic [7:0]        amt,
        input logic              imm,
        input logic              rrx,
        input logic              cin
    );
        logic [DATA_W-1:0]        s;
        logic                     sc;
        logic [DATA_W-1:0]        tmp;
        logic [2*DATA_W-1:0]      rot;
        logic signed [DATA_W-1:0] rs;
        logic [4:0]               n;
        n   = amt[4:0];
        rs  = $signed(r);
        s   = r;
        sc  = cin;
        tmp = '0;
        rot = '0;
        if (rrx) begin
            s  = {cin, r[DATA_W-1:1]};
            sc = r[0];
        end else begin
            case (typ)
                SH_LSL: begin
                    if (amt == 8'd0) begin
                        s  = r;
                        sc = cin;
                    end else if (amt < 8'd32) begin
                        s   = r << n;
                        tmp = r << (n - 5'd1);
                        sc  = tmp[DATA_W-1];
                    end else if (amt == 8'd32) begin
                        s  = '0;
                        sc = r[0];
                    end else begin
                        s  = '0;
                        sc = 1'b0;
                    end
                end
                SH_LSR: begin
                    if (amt == 8'd0 && imm) begin
                        s  = '0;
                        sc = r[DATA_W-1];
                    end else if (amt == 8'd0) begin
                        s  = r;
                        sc = cin;
                    end else if (amt < 8'd32) begin
                        s   = r >> n;
                        tmp = r >> (n - 5'd1);
                        sc  = tmp[0];
                    end else if (amt == 8'd32) begin
                        s  = '0;
                        sc = r[DATA_W-1];
                    end else begin
                        s  = '0;
                        sc = 1'b0;
                    end
                end
                SH_ASR: begin
                    if ((amt == 8'd0 && imm) || amt >= 8'd32) begin
                        s  = {DATA_W{r[DATA_W-1]}};
                        sc = r[DATA_W-1];
                    end else if (amt == 8'd0) begin
                        s  = r;
                        sc = cin;
                    end else begin
                        s   = rs >>> n;
                        tmp = r >> (n - 5'd1);
                        sc  = tmp[0];
                    end
                end
                default: begin
                    if (amt == 8'd0) begin
                        s  = r;
                        sc = cin;
                    end else if (n == 5'd0) begin
                        s  = r;
                        sc = r[DATA_W-1];
                    end else begin
                        rot = {r, r} >> n;
                        s   = rot[DATA_W-1:0];
                        tmp = r >> (n - 5'd1);
                        sc  = tmp[0];
                    end
                end
            endcase
        end
        return {sc, s};
    endfunction

    logic [7:0]        amt_latch;
    logic [DATA_W-1:0] op_b_latch;
    logic              op_b_carry_latch;

    logic [7:0]        amt_sel;
    logic [DATA_W:0]   shift_out;
    logic [DATA_W-1:0] shift_val;
    logic              shift_carry;
    logic [DATA_W-1:0] op_b;
    logic              op_b_carry;

    assign amt_sel     = shift_use_latch ? amt_latch : {3'b000, shift_amount};
    assign shift_out   = barrel_shift(r_in, shift_type, amt_sel, !shift_use_latch,
                                      shift_use_rrx, carry_in);
    assign shift_val   = shift_out[DATA_W-1:0];
    assign shift_carry = shift_out[DATA_W];

    always_comb begin
        op_b       = shift_val;
        op_b_carry = shift_carry;
        if (disable_op_b) begin
            op_b       = '0;
            op_b_carry = carry_in;
        end else if (use_op_b_latch) begin
            op_b       = op_b_latch;
            op_b_carry = op_b_carry_latch;
        end
    end

    // Latch stage: strobes capture at the edge, so a same-cycle use still sees the old value
    always_ff @(posedge clk) begin
        if (reset) begin
            amt_latch        <= '0;
            op_b_latch       <= '0;
            op_b_carry_latch <= 1'b0;
        end else begin
            if (shift_latch_amt) begin
                amt_latch <= r_in[7:0];
            end
            if (latch_op_b) begin
                op_b_latch       <= shift_val;
                op_b_carry_latch <= shift_carry;
            end
        end
    end

    logic [DATA_W-1:0] add_x;
    logic [DATA_W-1:0] add_y;
    logic              add_cy;
    logic [DATA_W:0]   sum;
    logic              arith;
    logic [DATA_W-1:0] res;
    logic              c_flag;
    logic              v_flag;
    logic              unused_flags;

    assign unused_flags = ^flags_in[3:1];

    // Subtractions are formed as x + ~y + cy so the carry out is directly NOT borrow
    always_comb begin
        add_x  = op_a;
        add_y  = op_b;
        add_cy = 1'b0;
        arith  = 1'b1;
        case (alu_op)
            OP_SUB, OP_CMP: begin add_x = op_a; add_y = ~op_b; add_cy = 1'b1;     end
            OP_RSB:         begin add_x = op_b; add_y = ~op_a; add_cy = 1'b1;     end
            OP_ADD, OP_CMN: begin add_x = op_a; add_y = op_b;  add_cy = 1'b0;     end
            OP_ADC:         begin add_x = op_a; add_y = op_b;  add_cy = carry_in; end
            OP_SBC:         begin add_x = op_a; add_y = ~op_b; add_cy = carry_in; end
            OP_RSC:         begin add_x = op_b; add_y = ~op_a; add_cy = carry_in; end
            default:        arith = 1'b0;
        endcase
        sum = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cy};

        res = sum[DATA_W-1:0];
        case (alu_op)
            OP_AND, OP_TST: res = op_a & op_b;
            OP_EOR, OP_TEQ: res = op_a ^ op_b;
            OP_ORR:         res = op_a | op_b;
            OP_MOV:         res = op_b;
            OP_BIC:         res = op_a & ~op_b;
            OP_MVN:         res = ~op_b;
            default:        res = sum[DATA_W-1:0];
        endcase

        if (arith) begin
            c_flag = sum[DATA_W];
            v_flag = (add_x[DATA_W-1] == add_y[DATA_W-1]) &&
                     (sum[DATA_W-1] != add_x[DATA_W-1]);
        end else begin
            c_flag = op_b_carry;
            v_flag = flags_in[0];
        end
    end

    assign result    = res;
    assign flags_out = {res[DATA_W-1], (res == '0), c_flag, v_flag};

endmodule

// File: tb/tb_alu_shifter.sv
// Scoreboard bench for alu_shifter: the driver queues hand-computed results,
// the monitor pops and compares whenever a vector is presented.
module tb_alu_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] op_a;
    logic [31:0] r_in;
    logic [3:0]  alu_op;
    logic [3:0]  flags_in;
    logic [1:0]  shift_type;
    logic [4:0]  shift_amount;
    logic        shift_latch_amt;
    logic        shift_use_latch;
    logic        shift_use_rrx;
    logic        carry_in;
    logic        latch_op_b;
    logic        use_op_b_latch;
    logic        disable_op_b;
    logic [31:0] result;
    logic [3:0]  flags_out;

    alu_shifter dut (
        .clk            (clk),
        .reset          (reset),
        .op_a           (op_a),
        .r_in           (r_in),
        .alu_op         (alu_op),
        .flags_in       (flags_in),
        .shift_type     (shift_type),
        .shift_amount   (shift_amount),
        .shift_latch_amt(shift_latch_amt),
        .shift_use_latch(shift_use_latch),
        .shift_use_rrx  (shift_use_rrx),
        .carry_in       (carry_in),
        .latch_op_b     (latch_op_b),
        .use_op_b_latch (use_op_b_latch),
        .disable_op_b   (disable_op_b),
        .result         (result),
        .flags_out      (flags_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        string       nm;
    } exp_t;

    exp_t sb_q[$];
    logic obs_vld = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Monitor: one queued expectation per presented vector
    always @(negedge clk) begin
        if (obs_vld) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: result=%h flags=%b, no expectation queued",
                         result, flags_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_cmp++;
                if (result !== e.res) begin
                    n_err++;
                    $display("FAIL %s result: got %h expected %h", e.nm, result, e.res);
                end
                n_cmp++;
                if (flags_out !== e.fl) begin
                    n_err++;
                    $display("FAIL %s nzcv: got %b expected %b", e.nm, flags_out, e.fl);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        obs_vld         = 1'b0;
        op_a            = '0;
        r_in            = '0;
        alu_op          = 4'hD;
        flags_in        = 4'b0000;
        shift_type      = 2'd0;
        shift_amount    = 5'd0;
        shift_latch_amt = 1'b0;
        shift_use_latch = 1'b0;
        shift_use_rrx   = 1'b0;
        carry_in        = 1'b0;
        latch_op_b      = 1'b0;
        use_op_b_latch  = 1'b0;
        disable_op_b    = 1'b0;
    endtask

    task automatic expect_vec(input logic [31:0] res, input logic [3:0] fl, input string nm);
        exp_t e;
        e.res = res;
        e.fl  = fl;
        e.nm  = nm;
        sb_q.push_back(e);
        obs_vld = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Latches cleared by reset
        step(); use_op_b_latch = 1; carry_in = 1;
        expect_vec(32'h0, 4'b0100, "rst_opb_latch");
        step(); shift_use_latch = 1; r_in = 32'h5; carry_in = 1;
        expect_vec(32'h5, 4'b0010, "rst_amt_latch");

        step(); alu_op = 4'h4; op_a = 32'h7FFF_FFFF; r_in = 32'h1;
        expect_vec(32'h8000_0000, 4'b1001, "add_ovf");
        step(); alu_op = 4'h2; op_a = 32'd5; r_in = 32'd5;
        expect_vec(32'h0, 4'b0110, "sub_eq");
        step(); alu_op = 4'hA; op_a = 32'd3; r_in = 32'd5;
        expect_vec(32'hFFFF_FFFE, 4'b1000, "cmp_lt");
        step(); r_in = 32'h8000_0001; shift_type = 2'd1; flags_in = 4'b0001;
        expect_vec(32'h0, 4'b0111, "mov_lsr32");
        step(); r_in = 32'h8000_0000; shift_type = 2'd2;
        expect_vec(32'hFFFF_FFFF, 4'b1010, "mov_asr32");
        step(); r_in = 32'h0000_000F; shift_type = 2'd3; shift_amount = 5'd4;
        expect_vec(32'hF000_0000, 4'b1010, "ror_imm4");
        step(); r_in = 32'h0000_00F8; shift_type = 2'd1; shift_amount = 5'd4;
        expect_vec(32'h0000_000F, 4'b0010, "lsr_imm4");
        step(); r_in = 32'h8000_0001; shift_amount = 5'd1;
        expect_vec(32'h0000_0002, 4'b0010, "lsl_imm1");

        // Register-specified amounts, including same-cycle latch + use
        step(); r_in = 32'h21; shift_latch_amt = 1;
        expect_vec(32'h21, 4'b0000, "latch_amt33");
        step(); r_in = 32'h20; shift_latch_amt = 1; shift_use_latch = 1;
        expect_vec(32'h0, 4'b0100, "lsl_reg33");
        step(); r_in = 32'h1; shift_use_latch = 1;
        expect_vec(32'h0, 4'b0110, "lsl_reg32");
        step(); r_in = 32'h1; shift_use_latch = 1; shift_type = 2'd3; carry_in = 1;
        expect_vec(32'h1, 4'b0000, "ror_reg32");

        step(); r_in = 32'h3; shift_use_rrx = 1; carry_in = 1;
        expect_vec(32'h8000_0001, 4'b1010, "rrx");
        step(); alu_op = 4'h5; op_a = 32'd1; r_in = 32'd1; carry_in = 1;
        expect_vec(32'd3, 4'b0000, "adc");
        step(); alu_op = 4'hF; op_a = 32'h1234; r_in = 32'h0;
        expect_vec(32'hFFFF_FFFF, 4'b1000, "mvn");
        step(); alu_op = 4'h3; op_a = 32'd1; r_in = 32'd3;
        expect_vec(32'd2, 4'b0010, "rsb");
        step(); alu_op = 4'h6; op_a = 32'd5; r_in = 32'd3;
        expect_vec(32'd1, 4'b0010, "sbc");
        step(); alu_op = 4'h7; op_a = 32'd3; r_in = 32'd1; carry_in = 1;
        expect_vec(32'hFFFF_FFFE, 4'b1000, "rsc");
        step(); alu_op = 4'h9; op_a = 32'hF0; r_in = 32'hF0; carry_in = 1; flags_in = 4'b0001;
        expect_vec(32'h0, 4'b0111, "teq");
        step(); alu_op = 4'hB; op_a = 32'hFFFF_FFFF; r_in = 32'h1;
        expect_vec(32'h0, 4'b0110, "cmn");
        step(); alu_op = 4'h4; op_a = 32'h8000_0000; r_in = 32'h8000_0000;
        expect_vec(32'h0, 4'b0111, "add_negovf");
        step(); alu_op = 4'hC; op_a = 32'h7; r_in = 32'h5; disable_op_b = 1; carry_in = 1;
        expect_vec(32'h7, 4'b0010, "orr_disable_b");

        // Operand-B latch, same-cycle latch + use, and clearing by reset
        step(); r_in = 32'h12; latch_op_b = 1;
        expect_vec(32'h12, 4'b0000, "latch_opb");
        step(); alu_op = 4'h4; op_a = 32'h1; r_in = 32'hFF; use_op_b_latch = 1;
        expect_vec(32'h13, 4'b0000, "use_opb");
        step(); alu_op = 4'h4; op_a = 32'h1; r_in = 32'h40; use_op_b_latch = 1; latch_op_b = 1;
        expect_vec(32'h13, 4'b0000, "opb_same_cycle");
        step(); alu_op = 4'h4; op_a = 32'h1; use_op_b_latch = 1;
        expect_vec(32'h41, 4'b0000, "opb_updated");
        step(); reset = 1'b1;
        step(); reset = 1'b0; use_op_b_latch = 1; carry_in = 1;
        expect_vec(32'h0, 4'b0100, "opb_after_reset");

        step();
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
